// File: rtl/cond_directive_filter.sv
// ---------------------------------------------------------------------------
// cond_directive_filter
//
// Streaming conditional-compilation filter placed in front of the module-body
// parser. Tokens arrive with their kind already decoded. IFDEF/IFNDEF/ELSIF
// tokens also carry the result of their macro lookup. A small stack records
// the state of each open conditional. Only TEXT tokens that belong to a live
// branch are passed on. Directives are always consumed, and EOF is always
// passed on as a last beat. Structural mistakes raise a sticky error that
// keeps the code of the first one seen.
//
// Ports
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   in_valid     : input token valid
//   in_ready     : input token accepted on in_valid & in_ready
//   in_kind      : 0 TEXT, 1 IFDEF, 2 IFNDEF, 3 ELSIF, 4 ELSE, 5 ENDIF,
//                  6 EOF, 7 treated as TEXT
//   in_defined   : macro-defined flag for IFDEF/IFNDEF/ELSIF
//   in_data      : TEXT payload
//   out_valid    : output beat valid
//   out_ready    : downstream accepts the beat
//   out_data     : forwarded payload (0 on the EOF beat)
//   out_last     : marks the EOF beat
//   depth        : current nesting depth
//   err          : sticky error flag
//   err_code     : first error seen: 0 none, 1 orphan, 2 order, 3 overflow,
//                  4 unterminated
// ---------------------------------------------------------------------------
module cond_directive_filter #(
  parameter int DATA_W    = 8,
  parameter int MAX_DEPTH = 8,
  localparam int DW       = $clog2(MAX_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic              in_defined,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [DW-1:0]     depth,
  output logic              err,
  output logic [2:0]        err_code
);

  localparam logic [2:0] K_IFDEF  = 3'd1;
  localparam logic [2:0] K_IFNDEF = 3'd2;
  localparam logic [2:0] K_ELSIF  = 3'd3;
  localparam logic [2:0] K_ELSE   = 3'd4;
  localparam logic [2:0] K_ENDIF  = 3'd5;
  localparam logic [2:0] K_EOF    = 3'd6;

  localparam logic [2:0] E_NONE    = 3'd0;
  localparam logic [2:0] E_ORPHAN  = 3'd1;
  localparam logic [2:0] E_ORDER   = 3'd2;
  localparam logic [2:0] E_OVERFLW = 3'd3;
  localparam logic [2:0] E_UNTERM  = 3'd4;

  // The stack is sized to the full range of the depth counter. This lets the
  // depth value index it directly without width adaptation. Slots at and
  // above MAX_DEPTH are never written.
  localparam int SLOTS = 1 << DW;
  localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);

  logic [SLOTS-1:0]  act_q;
  logic [SLOTS-1:0]  tkn_q;
  logic [SLOTS-1:0]  els_q;
  logic [SLOTS-1:0]  par_q;
  logic [DW-1:0]     depth_q;
  logic [DW-1:0]     top_idx;
  logic              at_zero;
  logic              at_max;
  logic              cur_active;
  logic              accept;
  logic              def_eff;
  logic [2:0]        err_new;

  assign in_ready   = ~out_valid | out_ready;
  assign accept     = in_valid & in_ready;
  assign at_zero    = (depth_q == '0);
  assign at_max     = (depth_q == MAX_D);
  assign top_idx    = depth_q - DW'(1);
  assign cur_active = at_zero ? 1'b1 : act_q[top_idx];
  assign def_eff    = (in_kind == K_IFNDEF) ? ~in_defined : in_defined;
  assign depth      = depth_q;

  // Classify the accepted token as a structural error, if it is one. A
  // non-zero code means the directive must leave the stack untouched. EOF is
  // the exception: it always clears the stack.
  always_comb begin
    err_new = E_NONE;
    if (accept) begin
      unique case (in_kind)
        K_IFDEF, K_IFNDEF: if (at_max) err_new = E_OVERFLW;
        K_ELSIF, K_ELSE: begin
          if (at_zero)                err_new = E_ORPHAN;
          else if (els_q[top_idx])    err_new = E_ORDER;
        end
        K_ENDIF:           if (at_zero) err_new = E_ORPHAN;
        K_EOF:             if (!at_zero) err_new = E_UNTERM;
        default: ;
      endcase
    end
  end

  // Output register, conditional stack and error latch. in_ready is only
  // high when the output slot is free or draining. A newly forwarded beat
  // therefore never overwrites one that is still waiting. The parent_active
  // bit is folded into ELSIF/ELSE activation. This keeps an inactive parent
  // from reviving a child branch, even though 'taken' already covers that
  // case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      depth_q   <= '0;
      act_q     <= '0;
      tkn_q     <= '0;
      els_q     <= '0;
      par_q     <= '0;
      err       <= 1'b0;
      err_code  <= E_NONE;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (!err && err_new != E_NONE) begin
        err      <= 1'b1;
        err_code <= err_new;
      end

      if (accept) begin
        unique case (in_kind)
          K_IFDEF, K_IFNDEF: begin
            if (err_new == E_NONE) begin
              par_q[depth_q] <= cur_active;
              act_q[depth_q] <= cur_active & def_eff;
              tkn_q[depth_q] <= ~cur_active | def_eff;
              els_q[depth_q] <= 1'b0;
              depth_q        <= depth_q + DW'(1);
            end
          end
          K_ELSIF: begin
            if (err_new == E_NONE) begin
              if (par_q[top_idx] && !tkn_q[top_idx] && in_defined) begin
                act_q[top_idx] <= 1'b1;
                tkn_q[top_idx] <= 1'b1;
              end else begin
                act_q[top_idx] <= 1'b0;
              end
            end
          end
          K_ELSE: begin
            if (err_new == E_NONE) begin
              act_q[top_idx] <= par_q[top_idx] & ~tkn_q[top_idx];
              tkn_q[top_idx] <= 1'b1;
              els_q[top_idx] <= 1'b1;
            end
          end
          K_ENDIF: begin
            if (err_new == E_NONE) depth_q <= top_idx;
          end
          K_EOF: begin
            out_valid <= 1'b1;
            out_data  <= '0;
            out_last  <= 1'b1;
            depth_q   <= '0;
            act_q     <= '0;
            tkn_q     <= '0;
            els_q     <= '0;
            par_q     <= '0;
          end
          default: begin
            if (cur_active) begin
              out_valid <= 1'b1;
              out_data  <= in_data;
              out_last  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cond_directive_filter.sv
// ---------------------------------------------------------------------------
// tb_cond_directive_filter
//
// Directed bench for cond_directive_filter. It uses two instances that share
// every input. The main one has MAX_DEPTH=8. A second one with MAX_DEPTH=2
// is used for the overflow case. A negedge monitor collects every accepted
// output beat into queues, which the scenario tasks then compare against
// hand-computed sequences.
// ---------------------------------------------------------------------------
module tb_cond_directive_filter;

  localparam logic [2:0] K_TEXT   = 3'd0;
  localparam logic [2:0] K_IFDEF  = 3'd1;
  localparam logic [2:0] K_IFNDEF = 3'd2;
  localparam logic [2:0] K_ELSIF  = 3'd3;
  localparam logic [2:0] K_ELSE   = 3'd4;
  localparam logic [2:0] K_ENDIF  = 3'd5;
  localparam logic [2:0] K_EOF    = 3'd6;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_kind;
  logic       in_defined;
  logic [7:0] in_data;
  logic       out_ready;

  logic       in_ready,  in_ready_b;
  logic       out_valid, out_valid_b;
  logic [7:0] out_data,  out_data_b;
  logic       out_last,  out_last_b;
  logic [3:0] depth;
  logic [1:0] depth_b;
  logic       err,       err_b;
  logic [2:0] err_code,  err_code_b;

  int total = 0;
  int bad   = 0;
  logic chk_ready = 1'b0;

  logic [7:0] got_d[$];
  logic       got_l[$];

  cond_directive_filter #(.DATA_W(8), .MAX_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_defined(in_defined), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .depth(depth), .err(err), .err_code(err_code)
  );

  cond_directive_filter #(.DATA_W(8), .MAX_DEPTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_kind(in_kind),
    .in_defined(in_defined), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_last(out_last_b), .depth(depth_b), .err(err_b), .err_code(err_code_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every beat that will be accepted at the coming rising edge. During
  // the backpressure scenario, also check that in_ready drops exactly while
  // a beat is stalled.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_l.push_back(out_last);
    end
    if (chk_ready) begin
      total++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        bad++;
        $display("[TB] FAIL bp_in_ready: in_ready=%b out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_kind = K_TEXT; in_defined = 1'b0; in_data = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    got_d.delete(); got_l.delete();
  endtask

  task automatic send(input logic [2:0] k, input logic d, input logic [7:0] x);
    int n = 0;
    in_valid = 1'b1; in_kind = k; in_defined = d; in_data = x;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 64) begin
        total++; bad++;
        $display("[TB] FAIL send_timeout: kind=%0d in_ready stuck at 0", k);
        in_valid = 1'b0;
        @(posedge clk); #1;
        return;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("[TB] FAIL rst_out_data: got %h want 00", out_data); end
    total++; if (out_last !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_last: got %b want 0", out_last); end
    total++; if (depth !== 4'd0) begin bad++; $display("[TB] FAIL rst_depth: got %0d want 0", depth); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL rst_err: got %b want 0", err); end
    total++; if (err_code !== 3'd0) begin bad++; $display("[TB] FAIL rst_err_code: got %0d want 0", err_code); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_elsif_select();
    apply_reset();
    send(K_IFDEF, 1'b0, 8'h00);
    send(K_TEXT,  1'b0, 8'h11);
    send(K_ELSIF, 1'b1, 8'h00);
    send(K_TEXT,  1'b0, 8'h22);
    send(K_ELSE,  1'b0, 8'h00);
    send(K_TEXT,  1'b0, 8'h33);
    send(K_ENDIF, 1'b0, 8'h00);
    send(K_EOF,   1'b0, 8'hFF);
    drain();
    total++; if (got_d.size() !== 2) begin bad++; $display("[TB] FAIL elsif_count: got %0d want 2", got_d.size()); end
    if (got_d.size() >= 2) begin
      total++; if (got_d[0] !== 8'h22 || got_l[0] !== 1'b0) begin bad++; $display("[TB] FAIL elsif_beat0: got %h/%b want 22/0", got_d[0], got_l[0]); end
      total++; if (got_d[1] !== 8'h00 || got_l[1] !== 1'b1) begin bad++; $display("[TB] FAIL elsif_eof: got %h/%b want 00/1", got_d[1], got_l[1]); end
    end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL elsif_err: got %b want 0", err); end
    total++; if (depth !== 4'd0) begin bad++; $display("[TB] FAIL elsif_depth: got %0d want 0", depth); end
  endtask

  task automatic test_else_fallback();
    apply_reset();
    send(K_IFDEF, 1'b0, 8'h00);
    send(K_ELSIF, 1'b0, 8'h00);
    send(K_TEXT,  1'b0, 8'hAA);
    send(K_ELSE,  1'b0, 8'h00);
    send(K_TEXT,  1'b0, 8'h5A);
    send(K_ENDIF, 1'b0, 8'h00);
    drain();
    total++; if (got_d.size() !== 1) begin bad++; $display("[TB] FAIL else_count: got %0d want 1", got_d.size()); end
    if (got_d.size() >= 1) begin
      total++; if (got_d[0] !== 8'h5A) begin bad++; $display("[TB] FAIL else_data: got %h want 5A", got_d[0]); end
    end
    total++; if (depth !== 4'd0) begin bad++; $display("[TB] FAIL else_depth: got %0d want 0", depth); end
  endtask

  task automatic test_nested();
    apply_reset();
    send(K_IFDEF, 1'b0, 8'h00);
    total++; if (depth !== 4'd1) begin bad++; $display("[TB] FAIL nest_depth1: got %0d want 1", depth); end
    send(K_IFDEF, 1'b1, 8'h00);
    total++; if (depth !== 4'd2) begin bad++; $display("[TB] FAIL nest_depth2: got %0d want 2", depth); end
    send(K_TEXT,  1'b0, 8'h77);
    send(K_ENDIF, 1'b0, 8'h00);
    send(K_ENDIF, 1'b0, 8'h00);
    drain();
    total++; if (got_d.size() !== 0) begin bad++; $display("[TB] FAIL nest_count: got %0d want 0", got_d.size()); end
    total++; if (depth !== 4'd0) begin bad++; $display("[TB] FAIL nest_depth_end: got %0d want 0", depth); end
    // An IFNDEF on an undefined macro opens a live branch
    send(K_IFNDEF, 1'b0, 8'h00);
    send(K_TEXT,   1'b0, 8'h66);
    send(K_ENDIF,  1'b0, 8'h00);
    drain();
    total++; if (got_d.size() !== 1) begin bad++; $display("[TB] FAIL ifndef_count: got %0d want 1", got_d.size()); end
    if (got_d.size() >= 1) begin
      total++; if (got_d[0] !== 8'h66) begin bad++; $display("[TB] FAIL ifndef_data: got %h want 66", got_d[0]); end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat = 4'b1001;
    apply_reset();
    chk_ready = 1'b1;
    fork
      begin
        for (int c = 0; c < 80; c++) begin
          out_ready = pat[c % 4];
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 16; i++) send(K_TEXT, 1'b0, 8'(8'h40 + i));
      end
    join
    drain();
    chk_ready = 1'b0;
    total++; if (got_d.size() !== 16) begin bad++; $display("[TB] FAIL bp_count: got %0d want 16", got_d.size()); end
    for (int i = 0; i < 16; i++) begin
      if (got_d.size() > i) begin
        total++;
        if (got_d[i] !== 8'(8'h40 + i)) begin bad++; $display("[TB] FAIL bp_data[%0d]: got %h want %h", i, got_d[i], 8'(8'h40 + i)); end
      end
    end
  endtask

  task automatic test_errors();
    apply_reset();
    send(K_ENDIF, 1'b0, 8'h00);
    total++; if (err !== 1'b1 || err_code !== 3'd1) begin bad++; $display("[TB] FAIL orphan: got %b/%0d want 1/1", err, err_code); end

    apply_reset();
    send(K_IFDEF, 1'b1, 8'h00);
    send(K_ELSE,  1'b0, 8'h00);
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL order_pre: got %b want 0", err); end
    send(K_ELSE,  1'b0, 8'h00);
    total++; if (err !== 1'b1 || err_code !== 3'd2) begin bad++; $display("[TB] FAIL order: got %b/%0d want 1/2", err, err_code); end
    total++; if (depth !== 4'd1) begin bad++; $display("[TB] FAIL order_depth: got %0d want 1", depth); end

    apply_reset();
    send(K_IFDEF, 1'b1, 8'h00);
    send(K_IFDEF, 1'b1, 8'h00);
    send(K_IFDEF, 1'b1, 8'h00);
    total++; if (err_b !== 1'b1 || err_code_b !== 3'd3) begin bad++; $display("[TB] FAIL overflow: got %b/%0d want 1/3", err_b, err_code_b); end
    total++; if (depth_b !== 2'd2) begin bad++; $display("[TB] FAIL overflow_depth: got %0d want 2", depth_b); end
    total++; if (err !== 1'b0 || depth !== 4'd3) begin bad++; $display("[TB] FAIL deep_no_overflow: got %b/%0d want 0/3", err, depth); end

    apply_reset();
    send(K_IFDEF, 1'b1, 8'h00);
    send(K_EOF,   1'b0, 8'h12);
    drain();
    total++; if (err !== 1'b1 || err_code !== 3'd4) begin bad++; $display("[TB] FAIL unterm: got %b/%0d want 1/4", err, err_code); end
    total++; if (depth !== 4'd0) begin bad++; $display("[TB] FAIL unterm_depth: got %0d want 0", depth); end
    total++; if (got_d.size() !== 1) begin bad++; $display("[TB] FAIL unterm_count: got %0d want 1", got_d.size()); end
    if (got_d.size() >= 1) begin
      total++; if (got_d[0] !== 8'h00 || got_l[0] !== 1'b1) begin bad++; $display("[TB] FAIL unterm_eof: got %h/%b want 00/1", got_d[0], got_l[0]); end
    end
  endtask

  task automatic test_sticky();
    apply_reset();
    send(K_ENDIF, 1'b0, 8'h00);
    send(K_IFDEF, 1'b1, 8'h00);
    send(K_TEXT,  1'b0, 8'h42);
    send(K_EOF,   1'b0, 8'h00);
    drain();
    total++; if (err !== 1'b1 || err_code !== 3'd1) begin bad++; $display("[TB] FAIL sticky_code: got %b/%0d want 1/1", err, err_code); end
    total++; if (got_d.size() !== 2) begin bad++; $display("[TB] FAIL sticky_count: got %0d want 2", got_d.size()); end
    if (got_d.size() >= 2) begin
      total++; if (got_d[0] !== 8'h42 || got_l[0] !== 1'b0) begin bad++; $display("[TB] FAIL sticky_text: got %h/%b want 42/0", got_d[0], got_l[0]); end
      total++; if (got_l[1] !== 1'b1) begin bad++; $display("[TB] FAIL sticky_eof: got %b want 1", got_l[1]); end
    end
    total++; if (depth !== 4'd0) begin bad++; $display("[TB] FAIL sticky_depth: got %0d want 0", depth); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    send(K_ENDIF, 1'b0, 8'h00);
    send(K_IFDEF, 1'b1, 8'h00);
    send(K_IFDEF, 1'b1, 8'h00);
    send(K_IFDEF, 1'b1, 8'h00);
    out_ready = 1'b0;
    send(K_TEXT,  1'b0, 8'h99);
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || out_data !== 8'h99) begin bad++; $display("[TB] FAIL stall_hold: got %b/%h want 1/99", out_valid, out_data); end
    total++; if (depth !== 4'd3 || err !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre: got %0d/%b want 3/1", depth, err); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_out_valid: got %b want 0", out_valid); end
    total++; if (depth !== 4'd0) begin bad++; $display("[TB] FAIL mid_depth: got %0d want 0", depth); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL mid_err: got %b want 0", err); end
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    got_d.delete(); got_l.delete();
    send(K_TEXT, 1'b0, 8'h3C);
    drain();
    total++; if (got_d.size() !== 1) begin bad++; $display("[TB] FAIL mid_after_count: got %0d want 1", got_d.size()); end
    if (got_d.size() >= 1) begin
      total++; if (got_d[0] !== 8'h3C) begin bad++; $display("[TB] FAIL mid_after_data: got %h want 3C", got_d[0]); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_kind = K_TEXT; in_defined = 1'b0; in_data = 8'h00;
    out_ready = 1'b1;
    #1;
    test_reset();
    test_elsif_select();
    test_else_fallback();
    test_nested();
    test_backpressure();
    test_errors();
    test_sticky();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
